uart_rx_fifo: RTL

Receive-side buffer between the UART receiver and the Wishbone-style peripheral bus. Captures each byte the receiver reports, stores it in a DEPTH-entry circular FIFO and lets the CPU pop bytes and read status through two bus registers. Prevents byte loss while the CPU is busy and raises an interrupt at a fill threshold or on overrun.

---
 rtl/uart_rx_fifo_pkg.sv | 24 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 58 +++++
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive FIFO: register offsets, STATUS layout,
// bus width and the bus handshake state encoding.
package uart_rx_fifo_pkg;

   localparam int UartDataBus = 32;

   localparam logic [1:0] UART_RX_DATA = 2'd0;
   localparam logic [1:0] UART_RX_STAT = 2'd1;

   localparam int STAT_EMPTY   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVERRUN = 2;
   localparam int STAT_COUNT   = 8;

   localparam int CTRL_CLR_OVR = 0;
   localparam int CTRL_FLUSH   = 1;

   typedef enum logic [1:0] {
      BUS_IDLE,
      BUS_ACK,
      BUS_HOLD
   } bus_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock circular FIFO with flush; a pop frees a slot for a push in the
// same cycle, so push+pop while full keeps the incoming word.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;
   assign rdata   = mem[rd_ptr];

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: bytes from the receiver enter a FIFO, the CPU pops them
// and reads/controls status over a two-register bus port.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int THRESHOLD = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             rx_data_i,
   input  logic                   rx_valid_i,
   input  logic [31:0]            bus_addr_i,
   input  logic [UartDataBus-1:0] bus_data_i,
   output logic [UartDataBus-1:0] bus_data_o,
   input  logic                   bus_select_i,
   input  logic                   bus_we_i,
   output logic                   bus_ack_o,
   output logic                   irq_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] THR = CW'(THRESHOLD);

   bus_state_e             state;
   logic                   overrun;
   logic [1:0]             reg_sel;
   logic                   access, pop, flush, clr_ovr, ovr_set;
   logic [7:0]             head;
   logic                   full, empty;
   logic [CW-1:0]          count;
   logic [UartDataBus-1:0] stat_word, rd_word;
   logic                   unused_bits;

   assign unused_bits = ^{bus_addr_i[31:4], bus_addr_i[1:0],
                          bus_data_i[UartDataBus-1:2]};

   assign reg_sel = bus_addr_i[3:2];
   assign access  = (state == BUS_IDLE) & bus_select_i;
   assign pop     = access & ~bus_we_i & (reg_sel == UART_RX_DATA);
   assign flush   = access & bus_we_i & (reg_sel == UART_RX_STAT) & bus_data_i[CTRL_FLUSH];
   assign clr_ovr = access & bus_we_i & (reg_sel == UART_RX_STAT) & bus_data_i[CTRL_CLR_OVR];
   // A pop on a full FIFO frees the slot, and a flush discards the byte quietly.
   assign ovr_set = rx_valid_i & full & ~pop & ~flush;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_valid_i),
      .wdata (rx_data_i),
      .pop   (pop),
      .flush (flush),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      stat_word                   = '0;
      stat_word[STAT_EMPTY]       = empty;
      stat_word[STAT_FULL]        = full;
      stat_word[STAT_OVERRUN]     = overrun;
      stat_word[STAT_COUNT +: CW] = count;
   end

   always_comb begin
      rd_word = '0;
      if (!bus_we_i) begin
         case (reg_sel)
            UART_RX_DATA: rd_word = empty ? '0 : {{(UartDataBus-8){1'b0}}, head};
            UART_RX_STAT: rd_word = stat_word;
            default:      rd_word = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= BUS_IDLE;
         bus_ack_o  <= 1'b0;
         bus_data_o <= '0;
      end else begin
         case (state)
            BUS_IDLE: begin
               if (bus_select_i) begin
                  bus_ack_o  <= 1'b1;
                  bus_data_o <= rd_word;
                  state      <= BUS_ACK;
               end
            end
            BUS_ACK: begin
               bus_ack_o <= 1'b0;
               state     <= BUS_HOLD;
            end
            BUS_HOLD: begin
               if (!bus_select_i) state <= BUS_IDLE;
            end
            default: begin
               bus_ack_o <= 1'b0;
               state     <= BUS_IDLE;
            end
         endcase
      end
   end

   // A new overrun beats a clear issued in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun <= 1'b0;
         irq_o   <= 1'b0;
      end else begin
         overrun <= ovr_set | (overrun & ~clr_ovr);
         irq_o   <= (count >= THR) | overrun;
      end
   end

endmodule
